// File: rtl/led_sweep_anim.sv
// LED sweep animator: sweeps a BAR_W-wide lit bar across N_LEDS outputs for N_PASSES passes.
// Optional bounce mode (direction toggles every pass) is enabled by defining LED_ANIM_BOUNCE_EN.
module led_sweep_anim #(
    parameter int unsigned N_LEDS      = 8,
    parameter int unsigned BAR_W       = 2,
    parameter int unsigned STEP_CYCLES = 2_500_000,
    parameter int unsigned N_PASSES    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              dir,
    input  logic              bounce,
    output logic [N_LEDS-1:0] leds,
    output logic              busy,
    output logic              done
);

    localparam int unsigned F  = N_LEDS + BAR_W - 1;
    localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned FW = (F > 1) ? $clog2(F) : 1;
    localparam int unsigned PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(F - 1);
    localparam logic [PW-1:0] PASS_LAST  = PW'(N_PASSES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     step_q;
    logic [FW-1:0]     frame_q;
    logic [PW-1:0]     pass_q;
    logic              dir_q;
    logic [N_LEDS-1:0] leds_q;
    logic              busy_q;
    logic              done_q;
    logic              dir_d;

    // Bar occupies bits k-BAR_W+1..k for a left sweep; right sweep is the mirror image.
    function automatic logic [N_LEDS-1:0] frame_pattern(input int unsigned k, input logic to_right);
        logic [N_LEDS-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            if ((i <= k) && (i + BAR_W > k)) begin
                if (to_right) pat[N_LEDS-1-i] = 1'b1;
                else          pat[i]          = 1'b1;
            end
        end
        return pat;
    endfunction

`ifdef LED_ANIM_BOUNCE_EN
    logic bounce_q;

    always_comb begin
        dir_d = bounce_q ? ~dir_q : dir_q;
    end
`else
    logic unused_bounce;
    assign unused_bounce = bounce;

    always_comb begin
        dir_d = dir_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            frame_q <= '0;
            pass_q  <= '0;
            dir_q   <= 1'b0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LED_ANIM_BOUNCE_EN
            bounce_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (trig) begin
                // Restart takes priority over any frame advance or completion this cycle.
                state_q <= RUN;
                step_q  <= '0;
                frame_q <= '0;
                pass_q  <= '0;
                dir_q   <= dir;
                leds_q  <= frame_pattern(0, dir);
                busy_q  <= 1'b1;
`ifdef LED_ANIM_BOUNCE_EN
                bounce_q <= bounce;
`endif
            end else if (state_q == RUN) begin
                if (step_q == STEP_LAST) begin
                    step_q <= '0;
                    if (frame_q == FRAME_LAST) begin
                        frame_q <= '0;
                        if (pass_q == PASS_LAST) begin
                            state_q <= IDLE;
                            leds_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                            dir_q  <= dir_d;
                            leds_q <= frame_pattern(0, dir_d);
                        end
                    end else begin
                        frame_q <= frame_q + 1'b1;
                        leds_q  <= frame_pattern(32'(frame_q) + 32'd1, dir_q);
                    end
                end else begin
                    step_q <= step_q + 1'b1;
                end
            end
        end
    end

    assign leds = leds_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
